// File: rtl/shift_frame_ctrl_pkg.sv
// Shared definitions for the shift-register frame sequencer: state codes,
// the byte-counter width helper and the default fill byte.
package shift_frame_ctrl_pkg;

  typedef logic [1:0] state_t;

  // state | meaning
  // FILL  | accepting real bytes from upstream
  // PAD   | shifting fill bytes to close a short frame
  // FULL  | word complete, presented downstream until accepted
  localparam state_t ST_FILL = 2'd0;
  localparam state_t ST_PAD  = 2'd1;
  localparam state_t ST_FULL = 2'd2;

  localparam logic [7:0] DEFAULT_PAD_BYTE = 8'h00;

  // Width needed to hold a byte count of 0..size inclusive.
  function automatic int cnt_width(input int size);
    return $clog2(size + 1);
  endfunction

endpackage

// File: rtl/shift_frame_byte_counter.sv
// Frame byte counter: total shifts (count) and real, non-pad bytes (real).
// Both saturate at SIZE and only return to zero through clear or reset.
module frame_byte_counter
  import shift_frame_ctrl_pkg::*;
#(
  parameter int SIZE = 8,
  parameter int CW   = cnt_width(SIZE)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc_i,
  input  logic          freeze_real_i,
  input  logic          clear_i,
  output logic [CW-1:0] count_o,
  output logic [CW-1:0] real_o,
  output logic          last_o,
  output logic          full_o
);

  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] real_q, real_d;

  // Next-count logic: clear wins, increments stop once the frame is full.
  always_comb begin
    count_d = count_q;
    real_d  = real_q;
    if (clear_i) begin
      count_d = '0;
      real_d  = '0;
    end else if (inc_i && !full_o) begin
      count_d = count_q + CW'(1);
      if (!freeze_real_i) begin
        real_d = real_q + CW'(1);
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      real_q  <= '0;
    end else begin
      count_q <= count_d;
      real_q  <= real_d;
    end
  end

  assign count_o = count_q;
  assign real_o  = real_q;
  assign last_o  = (count_q == CW'(SIZE - 1));
  assign full_o  = (count_q == CW'(SIZE));

endmodule

// File: rtl/shift_frame_ctrl.sv
// Sequencer for the byte-wide shift-register assembler. Accepts bytes over
// valid/ready, drives the assembler shift enable, pads short frames on flush
// and presents each finished word downstream with its real byte count.
// Optional idle auto-flush is built when SHIFT_FRAME_TIMEOUT_EN is defined;
// that build also adds the timeout_flag output.
module shift_frame_ctrl
  import shift_frame_ctrl_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter int               SIZE     = 8,
  parameter logic [WIDTH-1:0] PAD_BYTE = WIDTH'(DEFAULT_PAD_BYTE),
  parameter int               TIMEOUT  = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  input  logic                       flush,
  output logic                       sh_en,
  output logic [WIDTH-1:0]           sh_data,
  input  logic [WIDTH*SIZE-1:0]      sh_word,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH*SIZE-1:0]      out_word,
  output logic [cnt_width(SIZE)-1:0] out_bytes,
`ifdef SHIFT_FRAME_TIMEOUT_EN
  output logic                       timeout_flag,
`endif
  output logic                       busy
);

  localparam int CW = cnt_width(SIZE);

  if (SIZE < 2) begin : g_size_check
    $error("shift_frame_ctrl: SIZE must be at least 2");
  end
  if (TIMEOUT < 1) begin : g_timeout_check
    $error("shift_frame_ctrl: TIMEOUT must be at least 1");
  end

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_count, cnt_real;
  logic          cnt_last, cnt_full;
  logic          cnt_inc, cnt_freeze, cnt_clear;
  logic          accept;
  logic          flush_eff;

  assign in_ready = (state_q == ST_FILL);
  assign accept   = in_valid && in_ready;

`ifdef SHIFT_FRAME_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [TW-1:0] timer_q;
  logic          idle;
  logic          timeout_hit;

  assign idle        = (state_q == ST_FILL) && (cnt_count != '0) && !accept;
  assign timeout_hit = idle && (timer_q == '0);

  // Idle down-counter: reloads on any accept, outside FILL, or after firing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q <= TW'(TIMEOUT - 1);
    end else if (idle && (timer_q != '0)) begin
      timer_q <= timer_q - TW'(1);
    end else begin
      timer_q <= TW'(TIMEOUT - 1);
    end
  end

  assign timeout_flag = timeout_hit;
  assign flush_eff    = flush || timeout_hit;
`else
  assign flush_eff = flush;
`endif

  // Frame FSM: decides shifting, counter updates and the next state.
  always_comb begin
    state_d    = state_q;
    sh_en      = 1'b0;
    sh_data    = in_data;
    cnt_inc    = 1'b0;
    cnt_freeze = 1'b0;
    cnt_clear  = 1'b0;
    case (state_q)
      ST_FILL: begin
        if (accept) begin
          sh_en   = 1'b1;
          cnt_inc = 1'b1;
          // A byte that completes the frame absorbs a same-cycle flush.
          if (cnt_last) begin
            state_d = ST_FULL;
          end else if (flush_eff) begin
            state_d = ST_PAD;
          end
        end else if (flush_eff && (cnt_count != '0)) begin
          state_d = ST_PAD;
        end
      end
      ST_PAD: begin
        sh_en      = !cnt_full;
        sh_data    = PAD_BYTE;
        cnt_inc    = 1'b1;
        cnt_freeze = 1'b1;
        if (cnt_last) begin
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (out_ready) begin
          cnt_clear = 1'b1;
          state_d   = ST_FILL;
        end
      end
      default: begin
        state_d = ST_FILL;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_FILL;
    end else begin
      state_q <= state_d;
    end
  end

  frame_byte_counter #(
    .SIZE (SIZE),
    .CW   (CW)
  ) u_counter (
    .clk           (clk),
    .rst           (rst),
    .inc_i         (cnt_inc),
    .freeze_real_i (cnt_freeze),
    .clear_i       (cnt_clear),
    .count_o       (cnt_count),
    .real_o        (cnt_real),
    .last_o        (cnt_last),
    .full_o        (cnt_full)
  );

  assign out_valid = (state_q == ST_FULL);
  assign out_word  = sh_word;
  assign out_bytes = out_valid ? cnt_real : '0;
  assign busy      = (cnt_count != '0) || (state_q != ST_FILL);

endmodule

// File: tb/tb_shift_frame_ctrl.sv
// Bench for shift_frame_ctrl: an abstract frame model (list of real bytes,
// pending pad shifts, word-held flag) checked against the DUT every cycle,
// plus literal expectations for the directed scenarios.
module tb_shift_frame_ctrl;
  import shift_frame_ctrl_pkg::*;

  localparam int         WIDTH = 8;
  localparam int         SIZE  = 8;
  localparam int         BW    = cnt_width(SIZE);
  localparam logic [7:0] PAD   = 8'h00;

  logic                  clk;
  logic                  rst;
  logic                  in_valid;
  logic [WIDTH-1:0]      in_data;
  logic                  in_ready;
  logic                  flush;
  logic                  sh_en;
  logic [WIDTH-1:0]      sh_data;
  logic [WIDTH*SIZE-1:0] sh_word;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH*SIZE-1:0] out_word;
  logic [BW-1:0]         out_bytes;
  logic                  busy;
`ifdef SHIFT_FRAME_TIMEOUT_EN
  logic                  timeout_flag;
`endif

  shift_frame_ctrl #(
    .WIDTH    (WIDTH),
    .SIZE     (SIZE),
    .PAD_BYTE (PAD),
    .TIMEOUT  (255)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .flush        (flush),
    .sh_en        (sh_en),
    .sh_data      (sh_data),
    .sh_word      (sh_word),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_word     (out_word),
    .out_bytes    (out_bytes),
`ifdef SHIFT_FRAME_TIMEOUT_EN
    .timeout_flag (timeout_flag),
`endif
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Assembler stand-in: new byte enters the top lane, older bytes move down.
  initial sh_word = '0;
  always @(posedge clk) begin
    if (sh_en) sh_word <= {sh_data, sh_word[WIDTH*SIZE-1:WIDTH]};
  end

  int vectors     = 0;
  int miscompares = 0;
  int pad_cycles  = 0;
  int hs_count    = 0;

  logic [7:0] m_bytes[$];
  int         m_pad_left = 0;
  bit         m_hold     = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] m_word();
    logic [63:0] w;
    w = '0;
    for (int i = 0; i < SIZE; i++) begin
      w[i*8 +: 8] = (i < m_bytes.size()) ? m_bytes[i] : PAD;
    end
    return w;
  endfunction

  always @(posedge rst) begin
    m_bytes.delete();
    m_pad_left = 0;
    m_hold     = 1'b0;
  end

  // Per-cycle compare against the frame model, then advance the model with
  // the inputs the DUT will see at the next rising edge.
  always @(negedge clk) begin
    if (rst) begin
      m_bytes.delete();
      m_pad_left = 0;
      m_hold     = 1'b0;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_sh_en", sh_en, 0);
      chk("rst_out_bytes", out_bytes, 0);
      chk("rst_busy", busy, 0);
    end else begin
      bit e_ready, e_acc, e_shen;
      int n;
      e_ready = !m_hold && (m_pad_left == 0);
      e_acc   = in_valid && e_ready;
      e_shen  = e_acc || (m_pad_left > 0);
      chk("in_ready", in_ready, e_ready);
      chk("out_valid", out_valid, m_hold);
      chk("sh_en", sh_en, e_shen);
      chk("busy", busy, m_hold || (m_pad_left > 0) || (m_bytes.size() > 0));
      chk("out_bytes", out_bytes, m_hold ? m_bytes.size() : 0);
      if (e_shen) chk("sh_data", sh_data, (m_pad_left > 0) ? PAD : in_data);
      if (m_hold) chk("out_word", out_word, m_word());
      if (sh_en && !in_ready) pad_cycles++;
      if (out_valid && out_ready) hs_count++;
      if (m_hold) begin
        if (out_ready) begin
          m_hold = 1'b0;
          m_bytes.delete();
        end
      end else if (m_pad_left > 0) begin
        m_pad_left--;
        if (m_pad_left == 0) m_hold = 1'b1;
      end else begin
        if (e_acc) m_bytes.push_back(in_data);
        n = m_bytes.size();
        if (n == SIZE) m_hold = 1'b1;
        else if (flush && n > 0) m_pad_left = SIZE - n;
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic drive_byte(input logic [7:0] b, input logic fl);
    in_valid = 1'b1;
    in_data  = b;
    flush    = fl;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    chk("accept_wait", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic wait_valid();
    for (int k = 0; k < 40; k++) begin
      if (out_valid) break;
      @(posedge clk); #1;
    end
    chk("valid_wait", out_valid, 1);
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
    $fatal(1);
  end

  initial begin
    int p0, h0;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Full-rate frame.
    for (int i = 1; i <= 8; i++) drive_byte(8'(i), 1'b0);
    chk("t1_valid", out_valid, 1);
    chk("t1_word", out_word, 64'h0807060504030201);
    chk("t1_bytes", out_bytes, 8);
    chk("t1_ready_low", in_ready, 0);
    @(posedge clk); #1;
    chk("t1_ready_back", in_ready, 1);
    chk("t1_valid_drop", out_valid, 0);

    // Flush after three bytes; flush held into PAD must be ignored.
    out_ready = 1'b0;
    p0 = pad_cycles;
    drive_byte(8'hAA, 1'b0);
    drive_byte(8'hBB, 1'b0);
    drive_byte(8'hCC, 1'b0);
    flush = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    flush = 1'b0;
    wait_valid();
    chk("t2_pads", pad_cycles - p0, 5);
    chk("t2_word", out_word, 64'h0000000000CCBBAA);
    chk("t2_bytes", out_bytes, 3);
    out_ready = 1'b1;
    @(posedge clk); #1;

    // Flush together with the eighth byte: one frame, no padding.
    p0 = pad_cycles; h0 = hs_count;
    for (int i = 1; i <= 7; i++) drive_byte(8'(i), 1'b0);
    drive_byte(8'h08, 1'b1);
    chk("t3_valid", out_valid, 1);
    chk("t3_bytes", out_bytes, 8);
    repeat (4) begin @(posedge clk); #1; end
    chk("t3_frames", hs_count - h0, 1);
    chk("t3_pads", pad_cycles - p0, 0);

    // Backpressure with upstream valid and flush held during FULL.
    out_ready = 1'b0;
    for (int i = 8'h21; i <= 8'h28; i++) drive_byte(8'(i), 1'b0);
    h0 = hs_count;
    in_valid = 1'b1; in_data = 8'h99; flush = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("t4_word", out_word, 64'h2827262524232221);
      chk("t4_bytes", out_bytes, 8);
      chk("t4_ready", in_ready, 0);
      chk("t4_sh_en", sh_en, 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("t4_frames", hs_count - h0, 1);
    chk("t4_valid_drop", out_valid, 0);

    // Asynchronous reset mid-frame.
    for (int i = 8'h51; i <= 8'h55; i++) drive_byte(8'(i), 1'b0);
    #1 rst = 1'b1;
    #1;
    chk("t5_valid", out_valid, 0);
    chk("t5_busy", busy, 0);
    chk("t5_ready", in_ready, 1);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 8'h10; i <= 8'h17; i++) drive_byte(8'(i), 1'b0);
    chk("t5_word", out_word, 64'h1716151413121110);
    chk("t5_bytes", out_bytes, 8);
    out_ready = 1'b1;
    @(posedge clk); #1;

    // Flush on an empty frame is ignored.
    pulse_flush();
    @(posedge clk); #1;
    chk("t6_busy", busy, 0);
    chk("t6_ready", in_ready, 1);

    // Flush after seven bytes: a single pad shift.
    out_ready = 1'b0;
    p0 = pad_cycles;
    for (int i = 8'h61; i <= 8'h67; i++) drive_byte(8'(i), 1'b0);
    pulse_flush();
    wait_valid();
    chk("t7_pads", pad_cycles - p0, 1);
    chk("t7_word", out_word, 64'h0067666564636261);
    chk("t7_bytes", out_bytes, 7);
    out_ready = 1'b1;
    @(posedge clk); #1;

    // Flush with the very first byte: seven pad shifts.
    out_ready = 1'b0;
    p0 = pad_cycles;
    drive_byte(8'h71, 1'b1);
    wait_valid();
    chk("t8_pads", pad_cycles - p0, 7);
    chk("t8_word", out_word, 64'h0000000000000071);
    chk("t8_bytes", out_bytes, 1);
    out_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
